// File: rtl/mdsa_sort_ctrl.sv
// Shear-sort sequencer for the MDSA 2-D bitonic sorter: valid/ready tile load, PASSES snake row/column passes, trans strobe per pass.
// Latency: out_valid PASSES*(BSN_LAT+1) cycles after LOAD; holds in DONE while out_ready low. Optional MDSA_CTRL_PERF_EN adds sort_cycles.
module mdsa_sort_ctrl #(
  parameter  int N       = 8,
  parameter  int BSN_LAT = 6,
  localparam int PASSES  = 2*$clog2(N)+1,
  localparam int PW      = $clog2(PASSES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          desc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          sorter_en,
  output logic          sorter_start,
  output logic          sorter_trans,
  output logic [N-1:0]  sorter_dir,
  output logic          busy,
`ifdef MDSA_CTRL_PERF_EN
  output logic [15:0]   sort_cycles,
`endif
  output logic [PW-1:0] pass_idx
);

  localparam int CW = $clog2(BSN_LAT+1);
  localparam logic [CW-1:0] LAST = CW'(BSN_LAT-1);

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, TRANS, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pass_q, pass_d;
  logic [N-1:0]  dir_q, dir_d;
  logic          desc_q, desc_d;
  logic          in_ready_q, in_ready_d, start_q, start_d, trans_q, trans_d;
  logic          en_q, en_d, out_valid_q, out_valid_d, busy_q, busy_d;

  // Row passes snake (even BSNs ascending for ascending order); column passes all one way.
  function automatic logic [N-1:0] pass_dir(input logic [PW-1:0] p, input logic d);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = p[0] ? ~d : ((i % 2 == 0) ^ d);
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = LOAD;
      LOAD:    state_d = SETTLE;
      SETTLE:  if (cnt_q == LAST) state_d = (pass_q < PW'(PASSES-1)) ? TRANS : DONE;
      TRANS:   state_d = SETTLE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cnt_d  = (state_q == SETTLE && cnt_q != LAST) ? cnt_q + 1'b1 : '0;
    desc_d = (state_q == LOAD) ? desc : desc_q;

    pass_d = pass_q;
    if (state_d == LOAD)       pass_d = '0;
    else if (state_q == TRANS) pass_d = pass_q + 1'b1;

    // Outputs are flops, so they are decoded from the state being entered.
    dir_d = dir_q;
    if (state_d == SETTLE || state_d == TRANS || state_d == DONE) dir_d = pass_dir(pass_d, desc_d);

    in_ready_d  = (state_d == LOAD);
    start_d     = (state_d == LOAD);
    trans_d     = (state_d == LOAD) || (state_d == TRANS);
    en_d        = (state_d != IDLE);
    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pass_q      <= '0;
      dir_q       <= '0;
      desc_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      start_q     <= 1'b0;
      trans_q     <= 1'b0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pass_q      <= pass_d;
      dir_q       <= dir_d;
      desc_q      <= desc_d;
      in_ready_q  <= in_ready_d;
      start_q     <= start_d;
      trans_q     <= trans_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef MDSA_CTRL_PERF_EN
  logic [15:0] cyc_q, cyc_d, sc_q, sc_d;

  // cyc_q equals the cycle offset from LOAD, so DONE entry captures offset+1.
  always_comb begin
    cyc_d = cyc_q;
    if (state_q == LOAD) cyc_d = 16'd1;
    else if ((state_q == SETTLE || state_q == TRANS) && cyc_q != 16'hFFFF) cyc_d = cyc_q + 16'd1;
    sc_d = sc_q;
    if (state_d == DONE && state_q != DONE) sc_d = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= '0;
      sc_q  <= '0;
    end else begin
      cyc_q <= cyc_d;
      sc_q  <= sc_d;
    end
  end

  assign sort_cycles = sc_q;
`endif

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign sorter_en    = en_q;
  assign sorter_start = start_q;
  assign sorter_trans = trans_q;
  assign sorter_dir   = dir_q;
  assign busy         = busy_q;
  assign pass_idx     = pass_q;

endmodule
